// File: rtl/dm_store_buffer.sv
// dm_store_buffer: word-addressed data RAM behind an in-order store queue.
// Stores are accepted in one cycle and drain to RAM one per cycle. Loads see
// RAM merged with pending queue bytes, and the youngest entry wins per lane.
// A full-word debug/preload write shares the RAM write port and blocks draining.
// Optional build macro: DM_TRACE_EN prints one trace line for every drained store.
module dm_store_buffer #(
    parameter int ADDR_W = 12,
    parameter int DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [31:0]              m_data_addr,
    input  logic [3:0]               m_data_byteen,
    input  logic [31:0]              m_data_wdata,
    input  logic [31:0]              m_inst_addr,
    output logic [31:0]              m_data_rdata,
    output logic                     stall,
    input  logic                     dbg_we,
    input  logic [31:0]              dbg_addr,
    input  logic [31:0]              dbg_wdata,
    output logic [$clog2(DEPTH):0]   sb_count,
    output logic                     sb_empty
);

    localparam int PW    = $clog2(DEPTH);
    localparam int CW    = PW + 1;
    localparam int WORDS = 1 << ADDR_W;

    logic [31:0]       mem [0:WORDS-1];

    logic [ADDR_W-1:0] q_word [0:DEPTH-1];
    logic [3:0]        q_be   [0:DEPTH-1];
    logic [31:0]       q_data [0:DEPTH-1];
    logic [31:0]       q_pc   [0:DEPTH-1];

    logic [PW-1:0]     head;
    logic [PW-1:0]     tail;
    logic [CW-1:0]     count;

    logic [ADDR_W-1:0] ld_idx;
    logic [ADDR_W-1:0] st_idx;
    logic [ADDR_W-1:0] dbg_idx;
    logic              enq;
    logic              drain;
    logic [31:0]       drain_word;
    logic [31:0]       rd_merged;
    logic [PW-1:0]     fwd_idx;

    assign ld_idx  = m_data_addr[ADDR_W+1:2];
    assign st_idx  = m_data_addr[ADDR_W+1:2];
    assign dbg_idx = dbg_addr[ADDR_W+1:2];

    // Stall only looks at the registered count, so a drain in the same cycle
    // never frees a slot for a same-cycle refill.
    assign stall = (count == CW'(DEPTH)) && (|m_data_byteen);
    assign enq   = (|m_data_byteen) && !stall;
    assign drain = (count != '0) && !dbg_we;

    assign sb_count     = count;
    assign sb_empty     = (count == '0);
    assign m_data_rdata = rd_merged;

    // Head entry merged onto the current RAM word, written back on a drain.
    always_comb begin
        drain_word = mem[q_word[head]];
        for (int b = 0; b < 4; b++) begin
            if (q_be[head][b]) begin
                drain_word[8*b +: 8] = q_data[head][8*b +: 8];
            end
        end
    end

    // Load path: RAM word, then lanes overridden oldest-to-youngest so the
    // youngest matching entry ends up on top.
    always_comb begin
        rd_merged = mem[ld_idx];
        fwd_idx   = head;
        for (int i = 0; i < DEPTH; i++) begin
            fwd_idx = head + PW'(i);
            if ((CW'(i) < count) && (q_word[fwd_idx] == ld_idx)) begin
                for (int b = 0; b < 4; b++) begin
                    if (q_be[fwd_idx][b]) begin
                        rd_merged[8*b +: 8] = q_data[fwd_idx][8*b +: 8];
                    end
                end
            end
        end
    end

    // Queue pointers and occupancy; reset discards pending entries.
    always_ff @(posedge clk) begin
        if (!reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (enq) begin
                tail <= tail + PW'(1);
            end
            if (drain) begin
                head <= head + PW'(1);
            end
            if (enq && !drain) begin
                count <= count + CW'(1);
            end else if (!enq && drain) begin
                count <= count - CW'(1);
            end
        end
    end

    // Entry payload written at the tail; contents behind the pointers are don't-care.
    always_ff @(posedge clk) begin
        if (enq) begin
            q_word[tail] <= st_idx;
            q_be[tail]   <= m_data_byteen;
            q_data[tail] <= m_data_wdata;
            q_pc[tail]   <= m_inst_addr;
        end
    end

    // RAM write port: clear on reset, debug write has priority over draining.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int w = 0; w < WORDS; w++) begin
                mem[w] <= '0;
            end
        end else if (dbg_we) begin
            mem[dbg_idx] <= dbg_wdata;
        end else if (drain) begin
            mem[q_word[head]] <= drain_word;
        end
    end

`ifdef DM_TRACE_EN
    // Trace every drained store: time, pc, byte address and merged word.
    always_ff @(posedge clk) begin
        if (reset && drain) begin
            $display("%d@%h: *%h <= %h", $time, q_pc[head],
                     32'(q_word[head]) << 2, drain_word);
        end
    end
`endif

    // Address bits outside the word index and the pc field (used only by
    // the trace build) are intentionally not consumed by the datapath.
    logic unused_bits;
    assign unused_bits = ^{m_data_addr[31:ADDR_W+2], m_data_addr[1:0],
                           dbg_addr[31:ADDR_W+2], dbg_addr[1:0], q_pc[head]};

endmodule
